// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl_if
// Description : Byte handshake between a requester and the UART transmit
//               controller. A byte is transferred on any rising clock edge
//               where tx_valid and tx_ready are both high.
//
// Signals     : tx_valid  requester -> controller  byte available
//               tx_data   requester -> controller  byte to send (8 bits)
//               tx_ready  controller -> requester  controller is idle
//
// Modports    : master - requester side (drives tx_valid / tx_data)
//               slave  - controller side (drives tx_ready)
//
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_ctrl_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit controller. Accepts one byte per handshake and
//               serialises it as 1 start bit (0), 8 data bits LSB first,
//               an optional even-parity bit, and 1 stop bit (1). Every bit
//               lasts CLKS_PER_BIT clock cycles. The line idles high.
//
// Parameters  : CLKS_PER_BIT  clock cycles per serial bit (2..1023)
//
// Build macro : UART_TX_PARITY_EN - when defined, an even parity bit (XOR of
//               the captured byte) is sent between the data bits and the
//               stop bit. When undefined, the parity state and logic are
//               not built and DATA goes straight to STOP.
//
// Ports       : clk         clock, all state updates on the rising edge
//               n_rst       synchronous active-low reset
//               tx          handshake interface (slave modport):
//                             tx_valid / tx_data in, tx_ready out
//               serial_out  registered UART line, idle high
//               tx_busy     registered, high while a frame is in progress
//               tx_done     registered, one-cycle pulse in the first idle
//                           cycle after a frame completes
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 10
) (
  input  wire logic     clk,
  input  wire logic     n_rst,
  uart_tx_ctrl_if.slave tx,
  output logic          serial_out,
  output logic          tx_busy,
  output logic          tx_done
);

  // Bit timer width; guarded so a degenerate value still elaborates.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       C_LAST_DATA_IDX = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_bit_cnt;   // cycles elapsed within the current bit
  logic [2:0]       r_data_idx;  // which data bit is on the line
  logic [7:0]       r_shift;     // bit 0 is always the data bit being sent
`ifdef UART_TX_PARITY_EN
  logic             r_parity;    // even parity of the captured byte
`endif

  logic w_ready;
  logic w_handshake;
  logic w_bit_end;

  // Ready is a pure decode of the registered state, so it is glitch-free
  // and high in the very first cycle after reset release.
  assign w_ready     = (r_state == IDLE);
  assign w_handshake = tx.tx_valid & w_ready;
  assign w_bit_end   = (r_bit_cnt == C_BIT_LAST);
  assign tx.tx_ready = w_ready;

  // serial_out is always assigned on the edge that enters a state, so the
  // line already carries that state's value in its first cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_data_idx <= '0;
      r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
      serial_out <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      // tx_done is a single-cycle pulse; only the STOP exit raises it.
      tx_done <= 1'b0;

      case (r_state)
        IDLE: begin
          serial_out <= 1'b1;
          tx_busy    <= 1'b0;
          r_bit_cnt  <= '0;
          r_data_idx <= '0;
          if (w_handshake) begin
            r_shift    <= tx.tx_data;
`ifdef UART_TX_PARITY_EN
            r_parity   <= ^tx.tx_data;
`endif
            r_state    <= START;
            serial_out <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_bit_cnt  <= '0;
            r_state    <= DATA;
            serial_out <= r_shift[0];
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_shift   <= {1'b0, r_shift[7:1]};
            if (r_data_idx == C_LAST_DATA_IDX) begin
              r_data_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state    <= PARITY;
              serial_out <= r_parity;
`else
              r_state    <= STOP;
              serial_out <= 1'b1;
`endif
            end else begin
              r_data_idx <= r_data_idx + 1'b1;
              // Next bit is shift[1] now, which becomes shift[0] after
              // this edge's shift.
              serial_out <= r_shift[1];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_bit_cnt  <= '0;
            r_state    <= STOP;
            serial_out <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (w_bit_end) begin
            r_bit_cnt  <= '0;
            r_state    <= IDLE;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_bit_cnt  <= '0;
          r_data_idx <= '0;
          serial_out <= 1'b1;
          tx_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Directed self-checking bench for uart_tx_ctrl. Two instances
//               are built: one with CLKS_PER_BIT=10 and one with
//               CLKS_PER_BIT=2. Expected line values come from the byte
//               being sent (start 0, data LSB first, optional even parity,
//               stop 1). Honours UART_TX_PARITY_EN for the frame length.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;
  logic so_a, busy_a, done_a;
  logic so_b, busy_b, done_b;
  logic sel_b;
  logic cur_so, cur_busy, cur_done, cur_ready;

  uart_tx_ctrl_if if_a ();
  uart_tx_ctrl_if if_b ();

  uart_tx_ctrl #(.CLKS_PER_BIT(10)) dut_a (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx         (if_a),
    .serial_out (so_a),
    .tx_busy    (busy_a),
    .tx_done    (done_a)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(2)) dut_b (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx         (if_b),
    .serial_out (so_b),
    .tx_busy    (busy_b),
    .tx_done    (done_b)
  );

  assign cur_so    = sel_b ? so_b         : so_a;
  assign cur_busy  = sel_b ? busy_b       : busy_a;
  assign cur_done  = sel_b ? done_b       : done_a;
  assign cur_ready = sel_b ? if_b.tx_ready : if_a.tx_ready;

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Frame bit k is the line value in bit slot k (slot 0 = start bit).
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  // Called in the first cycle after the handshake edge. Checks every frame
  // cycle and leaves time in the cycle that should carry tx_done.
  // inj >= 0 pulses valid with 0xFF on dut_a at that cycle; rst_at >= 0
  // applies a one-cycle reset at that cycle and returns right after it.
  task automatic check_frame(input logic [10:0] fr, input int cpb,
                             input int inj, input int rst_at);
    for (int n = 0; n < cpb * FB; n++) begin
      chk("serial_out", cur_so, fr[n / cpb]);
      chk("tx_busy", cur_busy, 1'b1);
      chk("tx_done", cur_done, 1'b0);
      chk("tx_ready", cur_ready, 1'b0);
      if (inj >= 0 && n == inj) begin
        if_a.tx_valid = 1'b1;
        if_a.tx_data  = 8'hFF;
      end
      if (inj >= 0 && n == inj + 1) begin
        if_a.tx_valid = 1'b0;
      end
      if (n == rst_at) begin
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic check_done_cycle(input string tag);
    chk({tag, "_done"},  cur_done,  1'b1);
    chk({tag, "_ready"}, cur_ready, 1'b1);
    chk({tag, "_line"},  cur_so,    1'b1);
    chk({tag, "_busy"},  cur_busy,  1'b0);
  endtask

  task automatic send_a(input logic [7:0] b, input int inj);
    if_a.tx_valid = 1'b1;
    if_a.tx_data  = b;
    tick();
    if_a.tx_valid = 1'b0;
    check_frame(frame_of(b), 10, inj, -1);
    check_done_cycle("end");
    tick();
    chk("done_drop", cur_done, 1'b0);
    chk("idle_line", cur_so, 1'b1);
  endtask

  initial begin
    n_rst         = 1'b0;
    sel_b         = 1'b0;
    if_a.tx_valid = 1'b0;
    if_a.tx_data  = 8'h00;
    if_b.tx_valid = 1'b0;
    if_b.tx_data  = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_line", cur_so, 1'b1);
    chk("rst_busy", cur_busy, 1'b0);
    chk("rst_done", cur_done, 1'b0);
    n_rst = 1'b1;
    tick();
    chk("rel_ready", cur_ready, 1'b1);
    chk("rel_line", cur_so, 1'b1);
    chk("rel_busy", cur_busy, 1'b0);
    chk("rel_done", cur_done, 1'b0);

    // 0xA5: data 1,0,1,0,0,1,0,1; tx_done lands 10*FB+1 cycles after handshake
    send_a(8'hA5, -1);

    // Parity slot 1 for 0x07, 0 for 0x03 in the parity build
    send_a(8'h07, -1);
    send_a(8'h03, -1);

    // Back-to-back with tx_valid held high: 0x55 then 0xAA
    if_a.tx_valid = 1'b1;
    if_a.tx_data  = 8'h55;
    tick();
    if_a.tx_data  = 8'hAA;
    check_frame(frame_of(8'h55), 10, -1, -1);
    check_done_cycle("b2b1");
    tick();
    if_a.tx_valid = 1'b0;
    check_frame(frame_of(8'hAA), 10, -1, -1);
    check_done_cycle("b2b2");
    tick();
    chk("b2b_drop", cur_done, 1'b0);

    // 0xFF pulsed during data bit 2 of 0x3C must be ignored
    send_a(8'h3C, 3 * 10 + 5);
    repeat (12) begin
      chk("inj_no_done", cur_done, 1'b0);
      chk("inj_no_frame", cur_so, 1'b1);
      tick();
    end

    // One-cycle reset during data bit 4 (slot 5) of 0x0F
    if_a.tx_valid = 1'b1;
    if_a.tx_data  = 8'h0F;
    tick();
    if_a.tx_valid = 1'b0;
    check_frame(frame_of(8'h0F), 10, -1, 5 * 10 + 3);
    chk("mrst_line", cur_so, 1'b1);
    chk("mrst_busy", cur_busy, 1'b0);
    chk("mrst_ready", cur_ready, 1'b1);
    chk("mrst_done", cur_done, 1'b0);
    repeat (70) begin
      tick();
      chk("mrst_no_done", cur_done, 1'b0);
      chk("mrst_idle", cur_so, 1'b1);
    end

    // CLKS_PER_BIT = 2, byte 0x01
    sel_b = 1'b1;
    tick();
    chk("b_ready", cur_ready, 1'b1);
    if_b.tx_valid = 1'b1;
    if_b.tx_data  = 8'h01;
    tick();
    if_b.tx_valid = 1'b0;
    check_frame(frame_of(8'h01), 2, -1, -1);
    check_done_cycle("b_end");
    tick();
    chk("b_drop", cur_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10: clock cycles per serial bit; legal range 2..1023.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port n_rst, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port tx_valid, input, 1: requester has a byte to send.
REQ-005 SHALL have port tx_data, input, 8: byte to send; sampled only on handshake.
REQ-006 SHALL have port tx_ready, output, 1: controller can accept a byte.
REQ-007 SHALL have port serial_out, output, 1: UART line, idle high.
REQ-008 SHALL have port tx_busy, output, 1: a frame is in progress.
REQ-009 SHALL have port tx_done, output, 1: one-cycle pulse on frame completion.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only with TX_PARITY_EN defined.
REQ-011 SHALL drive tx_ready=1 exactly when state is IDLE; handshake = tx_valid & tx_ready on a rising edge.
REQ-012 SHALL capture tx_data into an internal 8-bit shift register on handshake and enter START on the same edge.
REQ-013 SHALL ignore tx_valid and tx_data while tx_ready=0; no queuing and no error flag.
REQ-014 SHALL register serial_out, so the line value for a state appears in the first cycle that state is current.
REQ-015 SHALL drive serial_out: IDLE 1, START 0, DATA shift-register bit 0, PARITY parity bit, STOP 1.
REQ-016 SHALL hold each of START, PARITY and STOP for exactly CLKS_PER_BIT cycles.
REQ-017 SHALL hold each of the 8 DATA bits for exactly CLKS_PER_BIT cycles, LSB first.
REQ-018 SHALL implement the bit timer as a counter of width clog2(CLKS_PER_BIT).
  - Counter clears on every state change and on every data-bit advance.
  - Counter wraps at CLKS_PER_BIT-1.
REQ-019 SHALL use a 3-bit data-bit counter.
  - Shift register shifts right by one at each data-bit boundary.
  - After bit 7 completes: PARITY when TX_PARITY_EN is defined, otherwise STOP.
REQ-020 SHALL return to IDLE after STOP completes, with tx_done=1 for exactly the first IDLE cycle.
REQ-021 SHALL allow back-to-back frames: a handshake in the tx_done cycle starts the next START on the following cycle, with no extra idle bit.
REQ-022 SHALL drive tx_busy=1 in every state except IDLE.
REQ-023 SHALL produce a frame of 10*CLKS_PER_BIT cycles from first START cycle to last STOP cycle, or 11*CLKS_PER_BIT with parity.

Reset
REQ-024 SHALL, on any rising edge with n_rst=0, force:
  - state IDLE
  - serial_out=1, tx_done=0, tx_busy=0
  - both counters and the shift register to 0
REQ-025 SHALL drive tx_ready=1 in the first cycle after reset release.
REQ-026 SHALL, on reset mid-frame, abandon the frame: serial_out=1 from the next edge and no tx_done pulse.

Configuration
REQ-027 SHALL, with macro UART_TX_PARITY_EN defined:
  - compute an even parity bit (XOR of the captured byte) at handshake;
  - transmit it in PARITY between DATA and STOP.
REQ-028 SHALL, without UART_TX_PARITY_EN, exclude the parity logic and the PARITY state entirely; DATA goes directly to STOP.

Verification
REQ-029 SHALL cover this scenario: CLKS_PER_BIT=10, no parity, send 0xA5.
  - serial_out = 0 for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles.
  - tx_done pulses once, 101 cycles after the handshake edge.
REQ-030 SHALL cover this scenario: parity build, send 0x07.
  - Parity slot = 1 for 10 cycles; frame is 110 cycles.
  - Send 0x03: parity slot = 0.
REQ-031 SHALL cover this scenario: hold tx_valid=1 continuously with 0x55 then 0xAA.
  - Second START begins on the cycle after the first tx_done; no idle-high gap.
REQ-032 SHALL cover this scenario: pulse tx_valid with 0xFF during DATA of an in-flight frame.
  - Byte ignored; the in-flight frame bits are unchanged.
  - Exactly one tx_done.
REQ-033 SHALL cover this scenario: assert n_rst=0 for one cycle during bit 4 of DATA.
  - serial_out=1, tx_busy=0, tx_ready=1 next cycle; no tx_done.
REQ-034 SHALL cover this scenario: CLKS_PER_BIT=2, send 0x01.
  - Each bit lasts exactly 2 cycles; frame is 20 cycles.
